// File: rtl/emib_ch_dly_model.sv
// ---------------------------------------------------------------------------
// emib_ch_dly_model
//   Clocked die-to-die EMIB channel model for AIB DV benches. Carries LANES
//   bits master->slave (m2s) and LANES bits slave->master (s2m). Each lane of
//   each direction has a programmable latency of 1 + dly cycles, a lane enable
//   that ties the output low, and a ready/valid config port that writes the
//   per-lane delay tables.
//
//   Optional feature: define EMIB_CH_FAULT_INJ_EN to build the LFSR-driven
//   fault injector on one m2s lane. Without it, i_flt_en and i_flt_lane are
//   ignored and o_flt_cnt is tied to 0.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_m2s_data / o_m2s_data   master transmit lanes / slave receive lanes
//   i_s2m_data / o_s2m_data   slave transmit lanes / master receive lanes
//   i_lane_en                 per-lane connect (0 = output tied low)
//   i_cfg_vld / o_cfg_rdy     config write handshake
//   i_cfg_dir                 0 = m2s table, 1 = s2m table
//   i_cfg_lane / i_cfg_dly    lane index / extra latency in cycles
//   o_cfg_err                 1-cycle pulse on an out-of-range lane write
//   i_flt_en / i_flt_lane     fault injection enable / targeted m2s lane
//   o_flt_cnt                 saturating injected-fault count
//
//   Requires MAX_DLY >= 2, 2**LANE_W >= LANES, 2**DLY_W >= MAX_DLY.
// ---------------------------------------------------------------------------
module emib_ch_dly_model #(
    parameter int          LANES     = 40,
    parameter int          LANE_W    = 6,
    parameter int          MAX_DLY   = 8,
    parameter int          DLY_W     = 3,
    parameter int          DLY_RST   = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [LANES-1:0]  i_m2s_data,
    output logic [LANES-1:0]  o_m2s_data,
    input  logic [LANES-1:0]  i_s2m_data,
    output logic [LANES-1:0]  o_s2m_data,
    input  logic [LANES-1:0]  i_lane_en,
    input  logic              i_cfg_vld,
    output logic              o_cfg_rdy,
    input  logic              i_cfg_dir,
    input  logic [LANE_W-1:0] i_cfg_lane,
    input  logic [DLY_W-1:0]  i_cfg_dly,
    output logic              o_cfg_err,
    input  logic              i_flt_en,
    input  logic [LANE_W-1:0] i_flt_lane,
    output logic [15:0]       o_flt_cnt
);

    typedef enum logic {S_IDLE, S_BUSY} cfg_state_t;

    cfg_state_t         r_state;
    logic               r_cfg_rdy;
    logic               r_cfg_err;
    logic [DLY_W-1:0]   r_m2s_dly [LANES];
    logic [DLY_W-1:0]   r_s2m_dly [LANES];
    logic [MAX_DLY-2:0] r_m2s_sr  [LANES];
    logic [MAX_DLY-2:0] r_s2m_sr  [LANES];
    logic [LANES-1:0]   r_m2s_out;
    logic [LANES-1:0]   r_s2m_out;

    // Tap vector: bit 0 is the live input, bit j is the input j cycles ago.
    logic [MAX_DLY-1:0] w_m2s_taps [LANES];
    logic [MAX_DLY-1:0] w_s2m_taps [LANES];
    logic [LANES-1:0]   w_flt_mask;
    logic               w_cfg_acc;
    logic               w_lane_ok;

    function automatic logic [DLY_W-1:0] sat_dly(input logic [DLY_W-1:0] d);
        if (int'(d) >= MAX_DLY)
            return DLY_W'(MAX_DLY - 1);
        return d;
    endfunction

    // Compare-based select keeps the index width independent of DLY_W.
    function automatic logic tap_sel(input logic [MAX_DLY-1:0] taps,
                                     input logic [DLY_W-1:0]   dly);
        logic t;
        t = 1'b0;
        for (int j = 0; j < MAX_DLY; j++)
            if (int'(dly) == j) t = taps[j];
        return t;
    endfunction

    assign w_cfg_acc = i_cfg_vld & r_cfg_rdy;
    assign w_lane_ok = (int'(i_cfg_lane) < LANES);

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_m2s_taps[k] = {r_m2s_sr[k], i_m2s_data[k]};
            w_s2m_taps[k] = {r_s2m_sr[k], i_s2m_data[k]};
        end
    end

`ifdef EMIB_CH_FAULT_INJ_EN
    logic [15:0] r_lfsr;
    logic [15:0] r_flt_cnt;
    logic        w_flt_hit;

    // A disabled lane never matches, so it is neither inverted nor counted.
    always_comb begin
        w_flt_mask = '0;
        for (int k = 0; k < LANES; k++)
            w_flt_mask[k] = i_flt_en && (r_lfsr[3:0] == 4'h0) &&
                            (int'(i_flt_lane) == k) && i_lane_en[k];
    end
    assign w_flt_hit = |w_flt_mask;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr    <= LFSR_SEED;
            r_flt_cnt <= 16'd0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            if (w_flt_hit && (r_flt_cnt != 16'hFFFF))
                r_flt_cnt <= r_flt_cnt + 16'd1;
        end
    end
    assign o_flt_cnt = r_flt_cnt;
`else
    logic w_flt_unused;
    assign w_flt_unused = ^{i_flt_en, i_flt_lane};
    assign w_flt_mask   = '0;
    assign o_flt_cnt    = 16'd0;
`endif

    // Delay lines and registered output taps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < LANES; k++) begin
                r_m2s_sr[k] <= '0;
                r_s2m_sr[k] <= '0;
            end
            r_m2s_out <= '0;
            r_s2m_out <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                r_m2s_sr[k]  <= w_m2s_taps[k][MAX_DLY-2:0];
                r_s2m_sr[k]  <= w_s2m_taps[k][MAX_DLY-2:0];
                r_m2s_out[k] <= i_lane_en[k] &
                                (tap_sel(w_m2s_taps[k], r_m2s_dly[k]) ^ w_flt_mask[k]);
                r_s2m_out[k] <= i_lane_en[k] & tap_sel(w_s2m_taps[k], r_s2m_dly[k]);
            end
        end
    end

    // Config FSM: one BUSY cycle after every accepted write, valid or not.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cfg_rdy <= 1'b1;
            r_cfg_err <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                r_m2s_dly[k] <= DLY_W'(DLY_RST);
                r_s2m_dly[k] <= DLY_W'(DLY_RST);
            end
        end else begin
            r_cfg_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_cfg_acc) begin
                        r_state   <= S_BUSY;
                        r_cfg_rdy <= 1'b0;
                        if (w_lane_ok) begin
                            for (int k = 0; k < LANES; k++) begin
                                if (int'(i_cfg_lane) == k) begin
                                    if (i_cfg_dir) r_s2m_dly[k] <= sat_dly(i_cfg_dly);
                                    else           r_m2s_dly[k] <= sat_dly(i_cfg_dly);
                                end
                            end
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    r_state   <= S_IDLE;
                    r_cfg_rdy <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cfg_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign o_m2s_data = r_m2s_out;
    assign o_s2m_data = r_s2m_out;
    assign o_cfg_rdy  = r_cfg_rdy;
    assign o_cfg_err  = r_cfg_err;

endmodule
